grab_seq_ctrl: RTL and testbench



---
 rtl/grab_seq_ctrl.sv | 280 ++++++++++++++++++++++++++++
 tb/tb_grab_seq_ctrl.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/grab_seq_ctrl.sv
// ---------------------------------------------------------------------------
// grab_seq_ctrl
//
// Frame-grab sequencer for the line/frame-valid generator in the receive
// clock domain. A grab copies its configuration into shadow registers, so the
// generator sees a constant timing_cycle/row_length for the whole grab. For
// each frame it emits rows+1 sync_x pulses, one every timing_cycle cycles;
// the generator drops the first sync of every frame. The sequencer then
// waits for the generator's fval to fall, which marks the end of the frame.
// Between frames it idles for the configured gap.
//
// Ports
//   clk_rxg       receive-domain clock
//   rst_rx        synchronous active-high reset
//   cfg_cycle     requested line period in clk_rxg cycles (>= MIN_CYCLE)
//   cfg_rows      requested rows per frame (>= 1)
//   cfg_frames    frames per grab, 0 = run until aborted
//   cfg_gap       idle cycles between frames (0 behaves as 1)
//   grab_start    one-cycle start pulse, only acted on while idle
//   grab_abort    one-cycle abort pulse
//   fval_in       frame-valid returned by the generator
//   sync_x        line sync pulse to the generator
//   timing_cycle  shadowed line period
//   row_length    shadowed row count
//   busy          high from an accepted start until DONE is left
//   frame_cnt     frames completed in the current grab (saturating)
//   grab_done     one-cycle completion pulse
//   err_cfg       sticky: a start was rejected for an illegal config
//   err_tmo       sticky: fval did not fall within TMO cycles
//
// All outputs are registered. Every output register is loaded from the value
// that the next-state logic computes for the following cycle.
// ---------------------------------------------------------------------------
module grab_seq_ctrl #(
    parameter int CYC_W     = 10,
    parameter int ROW_W     = 12,
    parameter int FRM_W     = 16,
    parameter int MIN_CYCLE = 130,
    parameter int TMO       = 4096
) (
    input  logic             clk_rxg,
    input  logic             rst_rx,
    input  logic [CYC_W-1:0] cfg_cycle,
    input  logic [ROW_W-1:0] cfg_rows,
    input  logic [FRM_W-1:0] cfg_frames,
    input  logic [FRM_W-1:0] cfg_gap,
    input  logic             grab_start,
    input  logic             grab_abort,
    input  logic             fval_in,
    output logic             sync_x,
    output logic [CYC_W-1:0] timing_cycle,
    output logic [ROW_W-1:0] row_length,
    output logic             busy,
    output logic [FRM_W-1:0] frame_cnt,
    output logic             grab_done,
    output logic             err_cfg,
    output logic             err_tmo
);

    // The pulse counter is one bit wider than the row count, so the value
    // rows+1 always fits.
    localparam int PUL_W = ROW_W + 1;
    localparam int TMO_W = (TMO > 1) ? $clog2(TMO) : 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARM,
        ST_ROW,
        ST_WAIT_FEND,
        ST_GAP,
        ST_DONE
    } state_t;

    state_t           state_reg,      state_next;
    logic [CYC_W-1:0] cyc_sh_reg,     cyc_sh_next;
    logic [ROW_W-1:0] rows_sh_reg,    rows_sh_next;
    logic [FRM_W-1:0] frames_sh_reg,  frames_sh_next;
    logic [FRM_W-1:0] gap_sh_reg,     gap_sh_next;
    logic [CYC_W-1:0] per_cnt_reg,    per_cnt_next;
    logic [PUL_W-1:0] pulse_cnt_reg,  pulse_cnt_next;
    logic [TMO_W-1:0] tmo_cnt_reg,    tmo_cnt_next;
    logic [FRM_W-1:0] gap_cnt_reg,    gap_cnt_next;
    logic [FRM_W-1:0] frame_cnt_reg,  frame_cnt_next;
    logic             abort_pend_reg, abort_pend_next;
    logic             fval_d_reg;
    logic             sync_x_reg,     sync_x_next;
    logic             busy_reg,       busy_next;
    logic             grab_done_reg,  grab_done_next;
    logic             err_cfg_reg,    err_cfg_next;
    logic             err_tmo_reg,    err_tmo_next;

    logic             cfg_ok;
    logic             last_period;
    logic             last_pulse;
    logic             fval_fall;
    logic             abort_now;
    logic [FRM_W-1:0] frame_inc;

    assign cfg_ok      = (cfg_cycle >= CYC_W'(MIN_CYCLE)) && (cfg_rows != '0);
    assign last_period = (per_cnt_reg == cyc_sh_reg - CYC_W'(1));
    assign last_pulse  = (pulse_cnt_reg == ({1'b0, rows_sh_reg} + PUL_W'(1)));
    assign fval_fall   = fval_d_reg && !fval_in;
    // An abort that arrives in the same cycle as the frame end still counts.
    assign abort_now   = abort_pend_reg || grab_abort;
    // frame_cnt saturates at all-ones; this only matters in continuous mode.
    assign frame_inc   = (frame_cnt_reg == '1) ? frame_cnt_reg
                                               : frame_cnt_reg + FRM_W'(1);

    // ---------------------------------------------------------------------
    // State and output registers
    // ---------------------------------------------------------------------
    always_ff @(posedge clk_rxg) begin
        if (rst_rx) begin
            state_reg      <= ST_IDLE;
            cyc_sh_reg     <= CYC_W'(MIN_CYCLE);
            rows_sh_reg    <= ROW_W'(1);
            frames_sh_reg  <= '0;
            gap_sh_reg     <= '0;
            per_cnt_reg    <= '0;
            pulse_cnt_reg  <= '0;
            tmo_cnt_reg    <= '0;
            gap_cnt_reg    <= '0;
            frame_cnt_reg  <= '0;
            abort_pend_reg <= 1'b0;
            fval_d_reg     <= 1'b0;
            sync_x_reg     <= 1'b0;
            busy_reg       <= 1'b0;
            grab_done_reg  <= 1'b0;
            err_cfg_reg    <= 1'b0;
            err_tmo_reg    <= 1'b0;
        end else begin
            state_reg      <= state_next;
            cyc_sh_reg     <= cyc_sh_next;
            rows_sh_reg    <= rows_sh_next;
            frames_sh_reg  <= frames_sh_next;
            gap_sh_reg     <= gap_sh_next;
            per_cnt_reg    <= per_cnt_next;
            pulse_cnt_reg  <= pulse_cnt_next;
            tmo_cnt_reg    <= tmo_cnt_next;
            gap_cnt_reg    <= gap_cnt_next;
            frame_cnt_reg  <= frame_cnt_next;
            abort_pend_reg <= abort_pend_next;
            fval_d_reg     <= fval_in;
            sync_x_reg     <= sync_x_next;
            busy_reg       <= busy_next;
            grab_done_reg  <= grab_done_next;
            err_cfg_reg    <= err_cfg_next;
            err_tmo_reg    <= err_tmo_next;
        end
    end

    // ---------------------------------------------------------------------
    // Next-state and output logic
    // ---------------------------------------------------------------------
    always_comb begin
        state_next      = state_reg;
        cyc_sh_next     = cyc_sh_reg;
        rows_sh_next    = rows_sh_reg;
        frames_sh_next  = frames_sh_reg;
        gap_sh_next     = gap_sh_reg;
        per_cnt_next    = per_cnt_reg;
        pulse_cnt_next  = pulse_cnt_reg;
        tmo_cnt_next    = tmo_cnt_reg;
        gap_cnt_next    = gap_cnt_reg;
        frame_cnt_next  = frame_cnt_reg;
        abort_pend_next = abort_pend_reg;
        err_cfg_next    = err_cfg_reg;
        err_tmo_next    = err_tmo_reg;

        unique case (state_reg)
            ST_IDLE: begin
                // A start pulse that coincides with an abort is still taken:
                // aborts are not looked at while idle.
                if (grab_start) begin
                    if (cfg_ok) begin
                        cyc_sh_next     = cfg_cycle;
                        rows_sh_next    = cfg_rows;
                        frames_sh_next  = cfg_frames;
                        gap_sh_next     = cfg_gap;
                        frame_cnt_next  = '0;
                        err_cfg_next    = 1'b0;
                        err_tmo_next    = 1'b0;
                        abort_pend_next = 1'b0;
                        state_next      = ST_ARM;
                    end else begin
                        err_cfg_next = 1'b1;
                    end
                end
            end

            ST_ARM: begin
                // Holds off for one cycle so that the shadow outputs are
                // already stable when the first sync is sent.
                per_cnt_next   = '0;
                pulse_cnt_next = '0;
                state_next     = grab_abort ? ST_DONE : ST_ROW;
            end

            ST_ROW: begin
                // The generator must receive the whole frame, so an abort
                // here is only noted and takes effect at the frame end.
                if (grab_abort) begin
                    abort_pend_next = 1'b1;
                end
                if (per_cnt_reg == '0) begin
                    pulse_cnt_next = pulse_cnt_reg + PUL_W'(1);
                end
                if (last_period) begin
                    per_cnt_next = '0;
                    if (last_pulse) begin
                        tmo_cnt_next = '0;
                        state_next   = ST_WAIT_FEND;
                    end
                end else begin
                    per_cnt_next = per_cnt_reg + CYC_W'(1);
                end
            end

            ST_WAIT_FEND: begin
                if (grab_abort) begin
                    abort_pend_next = 1'b1;
                end
                if (fval_fall) begin
                    frame_cnt_next = frame_inc;
                    if (((frames_sh_reg != '0) && (frame_inc == frames_sh_reg))
                        || abort_now) begin
                        state_next = ST_DONE;
                    end else begin
                        gap_cnt_next = '0;
                        state_next   = ST_GAP;
                    end
                end else if (tmo_cnt_reg == TMO_W'(TMO - 1)) begin
                    err_tmo_next = 1'b1;
                    state_next   = ST_DONE;
                end else begin
                    tmo_cnt_next = tmo_cnt_reg + TMO_W'(1);
                end
            end

            ST_GAP: begin
                if (grab_abort) begin
                    state_next = ST_DONE;
                end else if ((gap_sh_reg == '0) ||
                             (gap_cnt_reg == gap_sh_reg - FRM_W'(1))) begin
                    per_cnt_next   = '0;
                    pulse_cnt_next = '0;
                    state_next     = ST_ROW;
                end else begin
                    gap_cnt_next = gap_cnt_reg + FRM_W'(1);
                end
            end

            ST_DONE: begin
                abort_pend_next = 1'b0;
                state_next      = ST_IDLE;
            end

            default: begin
                state_next = ST_IDLE;
            end
        endcase

        // The outputs are computed one cycle ahead, so the registered copies
        // match state_reg. A sync goes out on every period-counter zero in
        // ROW.
        sync_x_next    = (state_next == ST_ROW) && (per_cnt_next == '0);
        busy_next      = (state_next != ST_IDLE);
        grab_done_next = (state_next == ST_DONE);
    end

    assign sync_x       = sync_x_reg;
    assign timing_cycle = cyc_sh_reg;
    assign row_length   = rows_sh_reg;
    assign busy         = busy_reg;
    assign frame_cnt    = frame_cnt_reg;
    assign grab_done    = grab_done_reg;
    assign err_cfg      = err_cfg_reg;
    assign err_tmo      = err_tmo_reg;

endmodule

// File: tb/tb_grab_seq_ctrl.sv
// ---------------------------------------------------------------------------
// Self-checking bench for grab_seq_ctrl.
// Expected sync_x and grab_done cycle numbers go into queues when a grab is
// started. A monitor pops these entries as the pulses appear. A generator
// model drives fval_in: it rises on the first sync of a frame and falls a
// fixed delay after the last sync. Configuration legality is covered by a
// table of vectors.
// ---------------------------------------------------------------------------
module tb_grab_seq_ctrl;

    localparam int CYC_W     = 10;
    localparam int ROW_W     = 12;
    localparam int FRM_W     = 16;
    localparam int MIN_CYCLE = 130;
    localparam int TMO       = 4096;
    localparam int FALL_DLY  = 20;

    logic             clk_rxg = 1'b0;
    logic             rst_rx  = 1'b1;
    logic [CYC_W-1:0] cfg_cycle  = '0;
    logic [ROW_W-1:0] cfg_rows   = '0;
    logic [FRM_W-1:0] cfg_frames = '0;
    logic [FRM_W-1:0] cfg_gap    = '0;
    logic             grab_start = 1'b0;
    logic             grab_abort = 1'b0;
    logic             fval_in;
    logic             sync_x;
    logic [CYC_W-1:0] timing_cycle;
    logic [ROW_W-1:0] row_length;
    logic             busy;
    logic [FRM_W-1:0] frame_cnt;
    logic             grab_done;
    logic             err_cfg;
    logic             err_tmo;

    grab_seq_ctrl #(
        .CYC_W(CYC_W), .ROW_W(ROW_W), .FRM_W(FRM_W),
        .MIN_CYCLE(MIN_CYCLE), .TMO(TMO)
    ) dut (
        .clk_rxg(clk_rxg), .rst_rx(rst_rx),
        .cfg_cycle(cfg_cycle), .cfg_rows(cfg_rows),
        .cfg_frames(cfg_frames), .cfg_gap(cfg_gap),
        .grab_start(grab_start), .grab_abort(grab_abort),
        .fval_in(fval_in), .sync_x(sync_x),
        .timing_cycle(timing_cycle), .row_length(row_length),
        .busy(busy), .frame_cnt(frame_cnt), .grab_done(grab_done),
        .err_cfg(err_cfg), .err_tmo(err_tmo)
    );

    always #5 clk_rxg = ~clk_rxg;

    int cyc = 0;
    always @(posedge clk_rxg) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;
    int sync_q[$];
    int done_q[$];

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s @cycle %0d: got %0d, required %0d",
                     name, cyc, act, req);
        end
    endtask

    // ---------------- generator model ----------------
    bit   gen_en = 1'b0;
    bit   fval_hi = 1'b0;
    logic gen_fval = 1'b0;
    int   gen_rows = 1;
    int   gen_cyc = 200;
    int   gen_cnt = 0;
    int   fall_at = -1;
    assign fval_in = fval_hi | gen_fval;

    initial begin
        forever begin
            @(negedge clk_rxg);
            if (!gen_en) begin
                gen_cnt  = 0;
                fall_at  = -1;
                gen_fval = 1'b0;
            end else begin
                if (fall_at == cyc) begin
                    gen_fval = 1'b0;
                    fall_at  = -1;
                end
                if (sync_x === 1'b1) begin
                    gen_cnt++;
                    if (gen_cnt == 1) gen_fval = 1'b1;
                    if (gen_cnt == gen_rows + 1) begin
                        fall_at = cyc + gen_cyc + FALL_DLY;
                        gen_cnt = 0;
                    end
                end
            end
        end
    end

    // ---------------- scoreboard monitor ----------------
    initial begin
        int e;
        forever begin
            @(negedge clk_rxg);
            while (sync_q.size() > 0 && sync_q[0] < cyc) begin
                e = sync_q.pop_front();
                n_cmp++; n_bad++;
                $display("FAIL sync_missed @cycle %0d: got none, required pulse at %0d", cyc, e);
            end
            while (done_q.size() > 0 && done_q[0] < cyc) begin
                e = done_q.pop_front();
                n_cmp++; n_bad++;
                $display("FAIL done_missed @cycle %0d: got none, required pulse at %0d", cyc, e);
            end
            if (sync_x !== 1'b0) begin
                if (sync_q.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL sync_unexpected @cycle %0d: got %b, required 0", cyc, sync_x);
                end else begin
                    e = sync_q.pop_front();
                    check("sync_time", cyc, e);
                end
            end
            if (grab_done !== 1'b0) begin
                if (done_q.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL done_unexpected @cycle %0d: got %b, required 0", cyc, grab_done);
                end else begin
                    e = done_q.pop_front();
                    check("done_time", cyc, e);
                end
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic tick(input int n);
        repeat (n) @(negedge clk_rxg);
    endtask

    task automatic wait_until(input int t);
        while (cyc < t) @(negedge clk_rxg);
    endtask

    // Drives a one-cycle start at the current negedge; returns its cycle.
    task automatic start_grab(input int c_len, input int rows, input int frames,
                              input int gap, input bit with_abort, output int c);
        cfg_cycle  = CYC_W'(c_len);
        cfg_rows   = ROW_W'(rows);
        cfg_frames = FRM_W'(frames);
        cfg_gap    = FRM_W'(gap);
        grab_start = 1'b1;
        grab_abort = with_abort;
        c = cyc;
        tick(1);
        grab_start = 1'b0;
        grab_abort = 1'b0;
    endtask

    // Pushes the rows+1 expected syncs of one frame. Returns the cycle at
    // which the generator model drops fval.
    task automatic push_frame(input int first, input int rows, input int c_len,
                              output int fall_d);
        for (int k = 0; k <= rows; k++) sync_q.push_back(first + k * c_len);
        fall_d = first + rows * c_len + c_len + FALL_DLY;
    endtask

    typedef struct {
        int cyc_v;
        int rows_v;
        bit accept;
    } cfg_vec_t;

    cfg_vec_t vecs[6];

    initial begin
        int c, d1, d2, d3, s2, s3, t_end;
        int exp_tc, exp_rl;

        vecs[0] = '{100,  4,    1'b0};
        vecs[1] = '{200,  0,    1'b0};
        vecs[2] = '{130,  1,    1'b1};
        vecs[3] = '{129,  4,    1'b0};
        vecs[4] = '{1023, 4095, 1'b1};
        vecs[5] = '{0,    0,    1'b0};

        // ---- reset values ----
        tick(3);
        rst_rx = 1'b0;
        tick(1);
        check("rst_sync_x", sync_x, 0);
        check("rst_busy", busy, 0);
        check("rst_grab_done", grab_done, 0);
        check("rst_err_cfg", err_cfg, 0);
        check("rst_err_tmo", err_tmo, 0);
        check("rst_frame_cnt", frame_cnt, 0);
        check("rst_timing_cycle", timing_cycle, MIN_CYCLE);
        check("rst_row_length", row_length, 1);

        // ---- two-frame grab: cycle 200, rows 4, gap 50 ----
        gen_en = 1'b1; gen_rows = 4; gen_cyc = 200;
        start_grab(200, 4, 2, 50, 1'b0, c);
        push_frame(c + 2, 4, 200, d1);
        s2 = d1 + 1 + 50;
        push_frame(s2, 4, 200, d2);
        done_q.push_back(d2 + 1);
        check("g1_busy", busy, 1);
        check("g1_timing_cycle", timing_cycle, 200);
        check("g1_row_length", row_length, 4);
        wait_until(d1);
        check("g1_fcnt_before", frame_cnt, 0);
        tick(1);
        check("g1_fcnt_after1", frame_cnt, 1);
        wait_until(d2 + 1);
        check("g1_busy_in_done", busy, 1);
        tick(1);
        check("g1_fcnt_final", frame_cnt, 2);
        check("g1_busy_after", busy, 0);
        exp_tc = 200; exp_rl = 4;

        // ---- config legality table (accepted grabs aborted in ARM) ----
        for (int i = 0; i < 6; i++) begin
            start_grab(vecs[i].cyc_v, vecs[i].rows_v, 1, 0, 1'b0, c);
            if (vecs[i].accept) begin
                exp_tc = vecs[i].cyc_v;
                exp_rl = vecs[i].rows_v;
            end
            check($sformatf("cfg%0d_busy", i), busy, vecs[i].accept);
            check($sformatf("cfg%0d_err_cfg", i), err_cfg, !vecs[i].accept);
            check($sformatf("cfg%0d_timing_cycle", i), timing_cycle, exp_tc);
            check($sformatf("cfg%0d_row_length", i), row_length, exp_rl);
            if (vecs[i].accept) begin
                grab_abort = 1'b1;
                done_q.push_back(c + 2);
            end
            tick(1);
            grab_abort = 1'b0;
            tick(1);
            check($sformatf("cfg%0d_busy_end", i), busy, 0);
        end

        // ---- continuous grab, abort during ROW of frame 3 ----
        gen_rows = 2; gen_cyc = 150;
        start_grab(150, 2, 0, 10, 1'b0, c);
        push_frame(c + 2, 2, 150, d1);
        push_frame(d1 + 11, 2, 150, d2);
        s3 = d2 + 11;
        push_frame(s3, 2, 150, d3);
        done_q.push_back(d3 + 1);
        wait_until(s3 + 10);
        grab_abort = 1'b1;
        tick(1);
        grab_abort = 1'b0;
        wait_until(d3 + 2);
        check("cont_fcnt", frame_cnt, 3);
        check("cont_busy", busy, 0);

        // ---- fval stuck high: timeout ----
        gen_en = 1'b0; fval_hi = 1'b1;
        start_grab(200, 2, 1, 0, 1'b0, c);
        push_frame(c + 2, 2, 200, d1);
        t_end = c + 2 + 2 * 200 + 200 + TMO;
        done_q.push_back(t_end);
        check("tmo_fcnt_clr", frame_cnt, 0);
        wait_until(t_end - 1);
        check("tmo_err_before", err_tmo, 0);
        tick(1);
        check("tmo_err_after", err_tmo, 1);
        tick(1);
        check("tmo_busy", busy, 0);
        fval_hi = 1'b0;
        gen_en = 1'b1;

        // ---- start+abort together, then config changed mid-grab ----
        gen_rows = 1; gen_cyc = 140;
        start_grab(140, 1, 1, 5, 1'b1, c);
        push_frame(c + 2, 1, 140, d1);
        done_q.push_back(d1 + 1);
        check("cc_busy", busy, 1);
        check("cc_err_tmo_clr", err_tmo, 0);
        wait_until(c + 5);
        cfg_cycle = CYC_W'(300);
        cfg_rows  = ROW_W'(7);
        grab_start = 1'b1;
        tick(1);
        grab_start = 1'b0;
        tick(4);
        check("cc_timing_cycle", timing_cycle, 140);
        check("cc_row_length", row_length, 1);
        wait_until(d1 + 2);
        check("cc_fcnt", frame_cnt, 1);
        check("cc_busy_end", busy, 0);

        // ---- reset during ROW, just before the second sync ----
        gen_en = 1'b0;
        start_grab(200, 4, 1, 0, 1'b0, c);
        sync_q.push_back(c + 2);
        wait_until(c + 201);
        rst_rx = 1'b1;
        tick(1);
        rst_rx = 1'b0;
        check("mrst_sync_x", sync_x, 0);
        check("mrst_busy", busy, 0);
        check("mrst_grab_done", grab_done, 0);
        check("mrst_timing_cycle", timing_cycle, MIN_CYCLE);
        check("mrst_row_length", row_length, 1);
        check("mrst_frame_cnt", frame_cnt, 0);
        tick(400);
        check("mrst_busy_stays", busy, 0);

        check("sync_q_empty", sync_q.size(), 0);
        check("done_q_empty", done_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // Stops a hung run.
    initial begin
        #600000;
        $display("FAIL watchdog @cycle %0d: got no end, required finish", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule
